verifier_check_h: RTL and testbench
===================================

// Module: verifier_check_h
// PURPOSE
//  Verifier-side consumer of the prover's h polynomial (degree nInBits, coefficients h_coeff[0]=const term).
//  After the final sumcheck round of a layer: checks h(0)==v0 and h(1)==v1 (the prover's claimed values at w1 and w2).
//  Then evaluates h(tau) (Horner) for the next layer's claim and computes w_next[i] = w1[i] + tau*(w2_m_w1[i]).
//  Uses one shared field_adder and one field_multiplier (en/ready handshake); arithmetic is mod F_Q.
// PARAMETERS
//  nInputs    8                  inputs of the layer; nInBits=$clog2(nInputs) must be >= 2
//  nInBits    $clog2(nInputs)    derived; do not override (elaboration error if mismatched)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous reset, active-high
//  en           in   1                  rising edge (en & ~en_dly) starts one check; a level held high does not retrigger
//  h_coeff      in   F_NBITS x (nInBits+1)  h coefficients, index = power of t
//  v0, v1       in   F_NBITS            expected h(0), h(1)
//  tau          in   F_NBITS            verifier challenge
//  w1           in   F_NBITS x nInBits  line start point
//  w2_m_w1      in   F_NBITS x nInBits  line direction
//  h_tau        out  F_NBITS            h(tau)
//  w_next       out  F_NBITS x nInBits  w1 + tau*(w2-w1)
//  ok           out  1                  1 iff h(0)==v0 and h(1)==v1; valid while ready=1 after a run
//  ready        out  1                  idle and no start this cycle
//  ready_pulse  out  1                  ready & ~ready_dly
// BEHAVIOUR
//  - Reset: state ST_IDLE, h_tau=0, w_next all 0, ok=0, ready=1, ready_pulse=0, en_dly=1 (en high at reset release is no start).
//  - All field inputs are required to be < F_Q; no input reduction performed.
//  - Start: h_coeff, v0, v1, tau, w1, w2_m_w1 are captured into internal regs on the start cycle; inputs may change afterwards.
//  - en rising edge while not ready: ignored (no queueing).
//  - Each field op: operands registered, enable pulsed for 1 cycle, result taken on first cycle with ~en_op_reg & op_ready.
//  - States / transitions:
//     ST_IDLE   -> ST_SUM1 on start; acc<=h_coeff[0]; zero_ok<=(h_coeff[0]==v0); k<=1.
//     ST_SUM1   acc<=acc+h_coeff[k]; k==nInBits -> ST_CHK1, else k++.
//     ST_CHK1   ok_r<=zero_ok & (acc==v1); acc<=h_coeff[nInBits]; k<=nInBits-1 -> ST_HMUL.
//     ST_HMUL   acc<=acc*tau -> ST_HADD.
//     ST_HADD   acc<=acc+h_coeff[k]; k==0 -> h_tau<=result, i<=0, ST_PMUL; else k--, ST_HMUL.
//     ST_PMUL   tmp<=tau*w2_m_w1[i] -> ST_PADD.
//     ST_PADD   w_next[i]<=w1[i]+tmp; i==nInBits-1 -> ST_DONE, else i++, ST_PMUL.
//     ST_DONE   ok<=ok_r -> ST_IDLE (ready rises next cycle; ready_pulse 1 cycle).
//  - Op count per run: 2*nInBits+... = nInBits adds (sum) + nInBits mul/add (Horner) + nInBits mul/add (point).
//  - Outputs h_tau/ok hold previous run's values until overwritten; ok cleared to 0 on start; w_next updated per element as computed.
//  - Check failure does not abort: h_tau and w_next are always computed.
//  - Wrap-around: sums exceeding F_Q reduce via field_adder (e.g. (q-1)+1 = 0).
//  - Reset asserted mid-run: immediate return to reset values next edge; in-flight adder/multiplier results discarded
//    (field units reset by the same rst).
//  - tau=0: h_tau=h_coeff[0], w_next=w1. tau=1: h_tau=h(1), w_next=w1+w2_m_w1.
// CONFIGURATION
//  VERIFIER_CHECK_H_STICKY_ERR_EN
//   defined:   extra output port err_sticky (1 bit, reset 0); set in ST_DONE when ok_r==0; cleared only by rst.
//              Intended to accumulate failures across all layers of a proof.
//   undefined: port absent; per-run ok is the only failure indication.
// TESTING  (nInputs=8 -> nInBits=3)
//  1. h_coeff={1,2,3,4}, v0=1, v1=10, tau=2, w1=5 (all i), w2_m_w1=3 -> ok=1, h_tau=49, w_next=11 (all i), one ready_pulse.
//  2. Same but v1=11 -> ok=0, h_tau=49, w_next=11; with _EN defined err_sticky=1 and stays 1 through next passing run.
//  3. h_coeff={q-1,1,0,0}, v0=q-1, v1=0, tau=q-1 -> ok=1, h_tau=q-2, w_next=w1 - w2_m_w1 mod q.
//  4. en held high for 3 runs' worth of time -> exactly one run; en pulsed while busy -> ignored, ready unchanged.
//  5. Inputs changed 1 cycle after start -> results match captured values from test 1.
//  6. rst asserted during ST_HMUL -> next cycle ready=1, ok=0, h_tau=0, w_next=0; following start completes correctly.

Source files
------------

// File: rtl/verifier_check_h.sv
// verifier_check_h: checks h(0)/h(1) against the prover's claims, then evaluates h(tau) and w_next = w1 + tau*(w2-w1).
// Optional macro VERIFIER_CHECK_H_STICKY_ERR_EN adds err_sticky, accumulating check failures until rst.

module field_adder #(
  parameter int unsigned W = 61,
  parameter logic [W-1:0] Q = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ready
);
  logic [W:0] w_sum;
  logic [W:0] w_sub;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_sub = w_sum - {1'b0, Q};

  // Single-cycle unit: the result is registered on the edge that samples en.
  assign ready = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else if (en) begin
      res <= (w_sum >= {1'b0, Q}) ? w_sub[W-1:0] : w_sum[W-1:0];
    end
  end
endmodule

// Two-cycle modular multiplier; reduction folds the high half, so Q must be 2^W-1.
module field_multiplier #(
  parameter int unsigned W = 61,
  parameter logic [W-1:0] Q = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ready
);
  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] r_prod;
  logic          r_stage;
  logic [W:0]    w_fold1;
  logic [W:0]    w_fold2;
  logic [W:0]    w_sub;

  assign w_fold1 = {1'b0, r_prod[W-1:0]} + {1'b0, r_prod[PW-1:W]};
  assign w_fold2 = {1'b0, w_fold1[W-1:0]} + (W+1)'(w_fold1[W]);
  assign w_sub   = w_fold2 - {1'b0, Q};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod  <= '0;
      r_stage <= 1'b0;
      res     <= '0;
      ready   <= 1'b1;
    end else begin
      r_stage <= 1'b0;
      if (en) begin
        r_prod  <= PW'(a) * PW'(b);
        r_stage <= 1'b1;
        ready   <= 1'b0;
      end else if (r_stage) begin
        res   <= (w_fold2 >= {1'b0, Q}) ? w_sub[W-1:0] : w_fold2[W-1:0];
        ready <= 1'b1;
      end
    end
  end
endmodule

module verifier_check_h #(
  parameter int unsigned nInputs = 8,
  parameter int unsigned nInBits = $clog2(nInputs),
  localparam int unsigned F_NBITS = 61
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [nInBits:0][F_NBITS-1:0]     h_coeff,
  input  logic [F_NBITS-1:0]                v0,
  input  logic [F_NBITS-1:0]                v1,
  input  logic [F_NBITS-1:0]                tau,
  input  logic [nInBits-1:0][F_NBITS-1:0]   w1,
  input  logic [nInBits-1:0][F_NBITS-1:0]   w2_m_w1,
  output logic [F_NBITS-1:0]                h_tau,
  output logic [nInBits-1:0][F_NBITS-1:0]   w_next,
  output logic                              ok,
  output logic                              ready,
  output logic                              ready_pulse
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
  ,
  output logic                              err_sticky
`endif
);
  localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};
  localparam int unsigned KW = $clog2(nInBits + 1);
  localparam int unsigned IW = $clog2(nInBits);

  if (nInBits != $clog2(nInputs) || nInBits < 2) begin : g_param_err
    $error("verifier_check_h: nInBits must equal $clog2(nInputs) and be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_SUM1, ST_CHK1, ST_HMUL, ST_HADD, ST_PMUL, ST_PADD, ST_DONE
  } state_t;

  state_t                            r_state;
  logic                              r_en_dly;
  logic                              r_ready_dly;
  logic                              r_busy;
  logic [KW-1:0]                     r_k;
  logic [IW-1:0]                     r_i;
  logic [F_NBITS-1:0]                r_acc;
  logic [F_NBITS-1:0]                r_tmp;
  logic                              r_zero_ok;
  logic                              r_chk_ok;
  logic [nInBits:0][F_NBITS-1:0]     r_hc;
  logic [F_NBITS-1:0]                r_v1;
  logic [F_NBITS-1:0]                r_tau;
  logic [nInBits-1:0][F_NBITS-1:0]   r_w1;
  logic [nInBits-1:0][F_NBITS-1:0]   r_w2m;

  logic                              r_add_en;
  logic [F_NBITS-1:0]                r_add_a;
  logic [F_NBITS-1:0]                r_add_b;
  logic                              r_mul_en;
  logic [F_NBITS-1:0]                r_mul_a;
  logic [F_NBITS-1:0]                r_mul_b;

  logic [F_NBITS-1:0]                w_add_res;
  logic                              w_add_rdy;
  logic [F_NBITS-1:0]                w_mul_res;
  logic                              w_mul_rdy;
  logic                              w_start;
  logic                              w_add_take;
  logic                              w_mul_take;

  field_adder #(.W(F_NBITS), .Q(F_Q)) u_add (
    .clk(clk), .rst(rst), .en(r_add_en), .a(r_add_a), .b(r_add_b),
    .res(w_add_res), .ready(w_add_rdy)
  );

  field_multiplier #(.W(F_NBITS), .Q(F_Q)) u_mul (
    .clk(clk), .rst(rst), .en(r_mul_en), .a(r_mul_a), .b(r_mul_b),
    .res(w_mul_res), .ready(w_mul_rdy)
  );

  assign w_start     = en & ~r_en_dly & (r_state == ST_IDLE);
  assign ready       = (r_state == ST_IDLE) & ~w_start;
  assign ready_pulse = ready & ~r_ready_dly;
  // A result is only trusted once our enable pulse has been seen by the unit.
  assign w_add_take  = r_busy & ~r_add_en & w_add_rdy;
  assign w_mul_take  = r_busy & ~r_mul_en & w_mul_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_en_dly    <= 1'b1;
      r_ready_dly <= 1'b1;
      r_busy      <= 1'b0;
      r_k         <= '0;
      r_i         <= '0;
      r_acc       <= '0;
      r_tmp       <= '0;
      r_zero_ok   <= 1'b0;
      r_chk_ok    <= 1'b0;
      r_hc        <= '0;
      r_v1        <= '0;
      r_tau       <= '0;
      r_w1        <= '0;
      r_w2m       <= '0;
      r_add_en    <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_mul_en    <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      h_tau       <= '0;
      w_next      <= '0;
      ok          <= 1'b0;
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
      err_sticky  <= 1'b0;
`endif
    end else begin
      r_en_dly    <= en;
      r_ready_dly <= ready;
      r_add_en    <= 1'b0;
      r_mul_en    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_hc      <= h_coeff;
            r_v1      <= v1;
            r_tau     <= tau;
            r_w1      <= w1;
            r_w2m     <= w2_m_w1;
            r_acc     <= h_coeff[0];
            r_zero_ok <= (h_coeff[0] == v0);
            r_k       <= KW'(1);
            r_busy    <= 1'b0;
            ok        <= 1'b0;
            r_state   <= ST_SUM1;
          end
        end
        // h(1) is the plain sum of all coefficients.
        ST_SUM1: begin
          if (!r_busy) begin
            r_add_a  <= r_acc;
            r_add_b  <= r_hc[r_k];
            r_add_en <= 1'b1;
            r_busy   <= 1'b1;
          end else if (w_add_take) begin
            r_acc  <= w_add_res;
            r_busy <= 1'b0;
            if (r_k == KW'(nInBits)) r_state <= ST_CHK1;
            else                     r_k     <= r_k + 1'b1;
          end
        end
        ST_CHK1: begin
          r_chk_ok <= r_zero_ok & (r_acc == r_v1);
          r_acc    <= r_hc[nInBits];
          r_k      <= KW'(nInBits - 1);
          r_state  <= ST_HMUL;
        end
        ST_HMUL: begin
          if (!r_busy) begin
            r_mul_a  <= r_acc;
            r_mul_b  <= r_tau;
            r_mul_en <= 1'b1;
            r_busy   <= 1'b1;
          end else if (w_mul_take) begin
            r_acc   <= w_mul_res;
            r_busy  <= 1'b0;
            r_state <= ST_HADD;
          end
        end
        ST_HADD: begin
          if (!r_busy) begin
            r_add_a  <= r_acc;
            r_add_b  <= r_hc[r_k];
            r_add_en <= 1'b1;
            r_busy   <= 1'b1;
          end else if (w_add_take) begin
            r_acc  <= w_add_res;
            r_busy <= 1'b0;
            if (r_k == '0) begin
              h_tau   <= w_add_res;
              r_i     <= '0;
              r_state <= ST_PMUL;
            end else begin
              r_k     <= r_k - 1'b1;
              r_state <= ST_HMUL;
            end
          end
        end
        ST_PMUL: begin
          if (!r_busy) begin
            r_mul_a  <= r_tau;
            r_mul_b  <= r_w2m[r_i];
            r_mul_en <= 1'b1;
            r_busy   <= 1'b1;
          end else if (w_mul_take) begin
            r_tmp   <= w_mul_res;
            r_busy  <= 1'b0;
            r_state <= ST_PADD;
          end
        end
        ST_PADD: begin
          if (!r_busy) begin
            r_add_a  <= r_w1[r_i];
            r_add_b  <= r_tmp;
            r_add_en <= 1'b1;
            r_busy   <= 1'b1;
          end else if (w_add_take) begin
            w_next[r_i] <= w_add_res;
            r_busy      <= 1'b0;
            if (r_i == IW'(nInBits - 1)) r_state <= ST_DONE;
            else begin
              r_i     <= r_i + 1'b1;
              r_state <= ST_PMUL;
            end
          end
        end
        ST_DONE: begin
          ok <= r_chk_ok;
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
          if (!r_chk_ok) err_sticky <= 1'b1;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_verifier_check_h.sv
// Bench for verifier_check_h: directed spec scenarios plus random runs against an arithmetic reference model.
// Define VERIFIER_CHECK_H_STICKY_ERR_EN to also check err_sticky.

module tb_verifier_check_h;
  localparam int unsigned NB = 3;
  localparam int unsigned FW = 61;
  localparam logic [127:0] Q   = (128'd1 << FW) - 128'd1;
  localparam logic [63:0]  Q64 = (64'd1 << FW) - 64'd1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [NB:0][FW-1:0]     h_coeff;
  logic [FW-1:0]           v0, v1, tau;
  logic [NB-1:0][FW-1:0]   w1, w2_m_w1;
  logic [FW-1:0]           h_tau;
  logic [NB-1:0][FW-1:0]   w_next;
  logic                    ok, ready, ready_pulse;
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
  logic                    err_sticky;
`endif

  verifier_check_h #(.nInputs(8)) dut (
    .clk(clk), .rst(rst), .en(en), .h_coeff(h_coeff), .v0(v0), .v1(v1), .tau(tau),
    .w1(w1), .w2_m_w1(w2_m_w1), .h_tau(h_tau), .w_next(w_next), .ok(ok),
    .ready(ready), .ready_pulse(ready_pulse)
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
    , .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] m_hc [NB+1];
  logic [FW-1:0] m_v0, m_v1, m_tau;
  logic [FW-1:0] m_w1 [NB];
  logic [FW-1:0] m_w2m [NB];
  logic          exp_ok;
  logic [63:0]   exp_htau;
  logic [63:0]   exp_w [NB];

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, expv);
    end
  endtask

  function automatic logic [FW-1:0] rand_fe();
    logic [63:0] r;
    case ($urandom_range(0, 7))
      0: return FW'(Q64 - 64'd1);
      1: return '0;
      default: begin
        r = {$urandom, $urandom};
        return FW'(r % Q64);
      end
    endcase
  endfunction

  // h evaluated directly as a sum of coefficient * power terms.
  task automatic ref_model();
    logic [127:0] h1, acc, pw;
    h1 = '0; acc = '0; pw = 128'd1;
    for (int j = 0; j <= NB; j++) begin
      h1  = (h1 + 128'(m_hc[j])) % Q;
      acc = (acc + 128'(m_hc[j]) * pw) % Q;
      pw  = (pw * 128'(m_tau)) % Q;
    end
    exp_ok   = (m_hc[0] == m_v0) && (h1 == 128'(m_v1));
    exp_htau = 64'(acc);
    for (int i = 0; i < NB; i++)
      exp_w[i] = 64'((128'(m_w1[i]) + 128'(m_tau) * 128'(m_w2m[i])) % Q);
  endtask

  task automatic drive_inputs();
    for (int j = 0; j <= NB; j++) h_coeff[j] = m_hc[j];
    v0 = m_v0; v1 = m_v1; tau = m_tau;
    for (int i = 0; i < NB; i++) begin
      w1[i] = m_w1[i];
      w2_m_w1[i] = m_w2m[i];
    end
  endtask

  task automatic scramble_inputs();
    for (int j = 0; j <= NB; j++) h_coeff[j] = rand_fe();
    v0 = rand_fe(); v1 = rand_fe(); tau = rand_fe();
    for (int i = 0; i < NB; i++) begin
      w1[i] = rand_fe();
      w2_m_w1[i] = rand_fe();
    end
  endtask

  task automatic set_t1();
    for (int j = 0; j <= NB; j++) m_hc[j] = FW'(j + 1);
    m_v0 = FW'(1); m_v1 = FW'(10); m_tau = FW'(2);
    for (int i = 0; i < NB; i++) begin
      m_w1[i] = FW'(5);
      m_w2m[i] = FW'(3);
    end
  endtask

  task automatic check_results(input string tag);
    check(tag, "ok", 64'(ok), 64'(exp_ok));
    check(tag, "h_tau", 64'(h_tau), exp_htau);
    for (int i = 0; i < NB; i++) check(tag, "w_next", 64'(w_next[i]), exp_w[i]);
  endtask

  task automatic run_and_check(input string tag, input bit scramble, input bit mid_pulse);
    bit seen;
    int extra;
    ref_model();
    drive_inputs();
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk); check(tag, "ready_on_start", 64'(ready), 64'd0);
    @(posedge clk); #1 en = 1'b0;
    if (scramble) scramble_inputs();
    @(negedge clk); check(tag, "ok_cleared", 64'(ok), 64'd0);
    if (mid_pulse) begin
      @(posedge clk); #1 en = 1'b1;
      @(negedge clk); check(tag, "ready_busy", 64'(ready), 64'd0);
      @(posedge clk); #1 en = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (ready_pulse) seen = 1'b1;
    end
    check(tag, "done_seen", 64'(seen), 64'd1);
    check(tag, "ready_done", 64'(ready), 64'd1);
    check_results(tag);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready_pulse) extra++;
    end
    check(tag, "extra_pulses", 64'(extra), 64'd0);
    check(tag, "ok_hold", 64'(ok), 64'(exp_ok));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1; en = 1'b1;
    set_t1(); drive_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "ready", 64'(ready), 64'd1);
    check("reset", "ok", 64'(ok), 64'd0);
    check("reset", "h_tau", 64'(h_tau), 64'd0);
    check("reset", "w_next0", 64'(w_next[0]), 64'd0);
    check("reset", "ready_pulse", 64'(ready_pulse), 64'd0);
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
    check("reset", "err_sticky", 64'(err_sticky), 64'd0);
`endif
    // en already high when reset releases must not start a run
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("en_at_reset", "ready", 64'(ready), 64'd1);
    check("en_at_reset", "h_tau", 64'(h_tau), 64'd0);
    @(posedge clk); #1 en = 1'b0;

    set_t1();
    run_and_check("t1", 1'b0, 1'b0);
    check("t1", "h_tau_const", 64'(h_tau), 64'd49);
    check("t1", "w_next_const", 64'(w_next[2]), 64'd11);
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
    check("t1", "err_sticky", 64'(err_sticky), 64'd0);
`endif

    set_t1(); m_v1 = FW'(11);
    run_and_check("t2", 1'b0, 1'b0);
    check("t2", "ok_const", 64'(ok), 64'd0);
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
    check("t2", "err_sticky", 64'(err_sticky), 64'd1);
`endif

    set_t1();
    m_hc[0] = FW'(Q64 - 64'd1); m_hc[1] = FW'(1); m_hc[2] = '0; m_hc[3] = '0;
    m_v0 = FW'(Q64 - 64'd1); m_v1 = '0; m_tau = FW'(Q64 - 64'd1);
    run_and_check("t3", 1'b0, 1'b0);
    check("t3", "h_tau_const", 64'(h_tau), Q64 - 64'd2);
    check("t3", "w_next_const", 64'(w_next[1]), 64'd2);
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
    check("t3", "err_sticky_hold", 64'(err_sticky), 64'd1);
`endif

    // en held high for about three runs' worth of cycles
    set_t1(); ref_model(); drive_inputs();
    @(posedge clk); #1 en = 1'b1;
    pulses = 0;
    repeat (150) begin
      @(negedge clk);
      if (ready_pulse) pulses++;
    end
    @(posedge clk); #1 en = 1'b0;
    check("t4_held", "pulses", 64'(pulses), 64'd1);
    check_results("t4_held");

    set_t1(); m_tau = FW'(7);
    run_and_check("t4_busy", 1'b0, 1'b1);

    set_t1();
    run_and_check("t5", 1'b1, 1'b0);
    check("t5", "h_tau_const", 64'(h_tau), 64'd49);

    // reset in the middle of the Horner multiply
    set_t1(); drive_inputs();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6", "ready", 64'(ready), 64'd1);
    check("t6", "ok", 64'(ok), 64'd0);
    check("t6", "h_tau", 64'(h_tau), 64'd0);
    for (int i = 0; i < NB; i++) check("t6", "w_next", 64'(w_next[i]), 64'd0);
`ifdef VERIFIER_CHECK_H_STICKY_ERR_EN
    check("t6", "err_sticky", 64'(err_sticky), 64'd0);
`endif
    set_t1(); m_tau = FW'(0);
    run_and_check("t6_after", 1'b0, 1'b0);
    check("t6_after", "h_tau_tau0", 64'(h_tau), 64'd1);

    for (int r = 0; r < 25; r++) begin
      logic [127:0] s;
      for (int j = 0; j <= NB; j++) m_hc[j] = rand_fe();
      m_tau = ($urandom_range(0, 5) == 0) ? FW'(1) : rand_fe();
      for (int i = 0; i < NB; i++) begin
        m_w1[i] = rand_fe();
        m_w2m[i] = rand_fe();
      end
      s = '0;
      for (int j = 0; j <= NB; j++) s = (s + 128'(m_hc[j])) % Q;
      m_v0 = $urandom_range(0, 3) == 0 ? rand_fe() : m_hc[0];
      m_v1 = $urandom_range(0, 3) == 0 ? rand_fe() : FW'(s);
      run_and_check("rand", r[0] == 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
